// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Bits needed to hold n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/md_cond_neg.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
module md_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit: restoring divide, shift-add (or single-cycle)
// multiply, cancel on flush, defined divide-by-zero result. Result is {hi, lo}.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_SEQ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic             op,
  input  logic             is_sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam int CW = clog2(WIDTH);

  state_t           r_state;
  logic             r_busy, r_ready, r_dbz;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [CW-1:0]    r_cnt;

  logic             r_op, r_sign, r_qneg, r_rneg, r_dbz_pend;
  logic [WIDTH-1:0] r_a, r_b, r_rem, r_quo, r_dvs;

  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_prod_fix, w_fast_prod;
  logic [WIDTH:0]     w_rem_sh, w_trial, w_sum;
  logic               w_fast_mul;

  md_cond_neg #(.WIDTH(WIDTH)) u_abs_a (
    .i_neg(r_sign & r_a[WIDTH-1]), .i_val(r_a), .o_val(w_abs_a));
  md_cond_neg #(.WIDTH(WIDTH)) u_abs_b (
    .i_neg(r_sign & r_b[WIDTH-1]), .i_val(r_b), .o_val(w_abs_b));
  md_cond_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .i_neg(r_qneg), .i_val(r_quo), .o_val(w_quo_fix));
  md_cond_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg(r_rneg), .i_val(r_rem), .o_val(w_rem_fix));
  md_cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_neg(r_qneg), .i_val({r_rem, r_quo}), .o_val(w_prod_fix));

  // Divide step works on {rem, quo}; multiply step adds into rem and shifts right.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvs};
  assign w_sum      = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvs} : '0);
  assign w_fast_mul = (MUL_SEQ == 0) && (op == OP_MUL);

  generate
    if (MUL_SEQ == 0) begin : g_fast
      logic signed [2*WIDTH-1:0] w_ma, w_mb;
      assign w_ma        = {{WIDTH{r_sign & r_a[WIDTH-1]}}, r_a};
      assign w_mb        = {{WIDTH{r_sign & r_b[WIDTH-1]}}, r_b};
      assign w_fast_prod = w_ma * w_mb;
    end else begin : g_seq
      assign w_fast_prod = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: if (start) begin
        r_op   <= op;
        r_sign <= is_sign;
        r_a    <= a;
        r_b    <= b;
      end
      PREP: begin
        r_qneg     <= r_sign & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_rneg     <= r_sign & r_a[WIDTH-1];
        r_dbz_pend <= (r_b == '0);
        r_rem      <= '0;
        if (r_op == OP_DIV) begin
          r_quo <= w_abs_a;
          r_dvs <= w_abs_b;
        end else begin
          r_quo <= w_abs_b;
          r_dvs <= w_abs_a;
        end
      end
      CALC: if (r_op == OP_DIV) begin
        r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
      end else begin
        r_rem <= w_sum[WIDTH:1];
        r_quo <= {w_sum[0], r_quo[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  // Control FSM with registered busy/ready and the result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else if (cancel) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (start) begin
            r_busy  <= 1'b1;
            r_state <= w_fast_mul ? FIX : PREP;
          end
        end
        PREP: begin
          r_cnt   <= CW'(WIDTH - 1);
          r_state <= CALC;
        end
        CALC: begin
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        FIX: begin
          if (r_op == OP_DIV) begin
            r_dbz <= r_dbz_pend;
            if (r_dbz_pend) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end else begin
            r_dbz <= 1'b0;
            if (MUL_SEQ == 0) {r_hi, r_lo} <= w_fast_prod;
            else              {r_hi, r_lo} <= w_prod_fix;
          end
          r_ready <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign ready = r_ready;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign dbz   = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: 32-bit sequential, 32-bit fast-multiply and 8-bit instances.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  start_v  = '0;
  logic [2:0]  cancel_v = '0;
  logic [2:0]  op_v     = '0;
  logic [2:0]  sgn_v    = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [7:0]  a2 = '0, b2 = '0;
  wire  [2:0]  busy_v, ready_v, dbz_v;
  wire  [31:0] hi0, lo0, hi1, lo1;
  wire  [7:0]  hi2, lo2;

  int vectors = 0;
  int miscompares = 0;

  muldiv_seq #(.WIDTH(32), .MUL_SEQ(1)) u_seq (
    .clk(clk), .rst(rst_n), .start(start_v[0]), .cancel(cancel_v[0]), .op(op_v[0]),
    .is_sign(sgn_v[0]), .a(a0), .b(b0), .busy(busy_v[0]), .ready(ready_v[0]),
    .hi(hi0), .lo(lo0), .dbz(dbz_v[0]));

  muldiv_seq #(.WIDTH(32), .MUL_SEQ(0)) u_fast (
    .clk(clk), .rst(rst_n), .start(start_v[1]), .cancel(cancel_v[1]), .op(op_v[1]),
    .is_sign(sgn_v[1]), .a(a1), .b(b1), .busy(busy_v[1]), .ready(ready_v[1]),
    .hi(hi1), .lo(lo1), .dbz(dbz_v[1]));

  muldiv_seq #(.WIDTH(8), .MUL_SEQ(1)) u_w8 (
    .clk(clk), .rst(rst_n), .start(start_v[2]), .cancel(cancel_v[2]), .op(op_v[2]),
    .is_sign(sgn_v[2]), .a(a2), .b(b2), .busy(busy_v[2]), .ready(ready_v[2]),
    .hi(hi2), .lo(lo2), .dbz(dbz_v[2]));

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic o, input logic s,
                                input logic [31:0] aa, input logic [31:0] bb,
                                output logic [31:0] mh, output logic [31:0] ml,
                                output logic md);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, aa} & mask;
    ub = {32'b0, bb} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (s && aa[w-1]) sa = sa - longint'(64'd1 << w);
    if (s && bb[w-1]) sb = sb - longint'(64'd1 << w);
    md = 1'b0;
    if (o) begin
      if (ub == 64'd0) begin
        mh = ua[31:0];
        ml = mask[31:0];
        md = 1'b1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        mh = 32'(r) & mask[31:0];
        ml = 32'(q) & mask[31:0];
      end
    end else begin
      p = sa * sb;
      mh = 32'(p >> w) & mask[31:0];
      ml = 32'(p) & mask[31:0];
    end
  endfunction

  function automatic int width_of(input int d);
    return (d == 2) ? 8 : 32;
  endfunction

  // Launch one operation, keep start high until ready, return latency and result.
  task automatic do_op(input int d, input logic o, input logic s,
                       input logic [31:0] aa, input logic [31:0] bb,
                       output int lat, output logic [31:0] rh,
                       output logic [31:0] rl, output logic rd);
    case (d)
      0: begin a0 = aa; b0 = bb; end
      1: begin a1 = aa; b1 = bb; end
      default: begin a2 = aa[7:0]; b2 = bb[7:0]; end
    endcase
    op_v[d] = o;
    sgn_v[d] = s;
    start_v[d] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready_v[d] && lat < 200);
    start_v[d] = 1'b0;
    case (d)
      0: begin rh = hi0; rl = lo0; end
      1: begin rh = hi1; rl = lo1; end
      default: begin rh = {24'b0, hi2}; rl = {24'b0, lo2}; end
    endcase
    rd = dbz_v[d];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy_v !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_busy: got %b, want 000", busy_v);
    end
    vectors++;
    if (ready_v !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, want 000", ready_v);
    end
    vectors++;
    if (dbz_v !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_dbz: got %b, want 000", dbz_v);
    end
    vectors++;
    if ({hi0, lo0, hi1, lo1, hi2, lo2} !== '0) begin
      miscompares++;
      $display("FAIL reset_result: got %h %h %h %h %h %h, want all zero",
               hi0, lo0, hi1, lo1, hi2, lo2);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        o;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [8];
    int lat;
    logic [31:0] rh, rl;
    logic rd;
    tbl[0] = '{1'b1, 1'b0, 32'd100,        32'd7,        32'd2,        32'd14,       1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h1234,       32'h0,        32'h1234,     32'hFFFFFFFF, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'hFFFFFFFD,   32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'hFFFFFFF8,   32'h0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_op(0, tbl[i].o, tbl[i].s, tbl[i].a, tbl[i].b, lat, rh, rl, rd);
      vectors++;
      if (lat !== 35) begin
        miscompares++;
        $display("FAIL dir_latency[%0d]: got %0d cycles, want 35", i, lat);
      end
      vectors++;
      if ({rh, rl, rd} !== {tbl[i].eh, tbl[i].el, tbl[i].ed}) begin
        miscompares++;
        $display("FAIL dir_result[%0d]: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                 i, rh, rl, rd, tbl[i].eh, tbl[i].el, tbl[i].ed);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fast_mul();
    int lat;
    logic [31:0] rh, rl;
    logic rd;
    do_op(1, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, lat, rh, rl, rd);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL fast_mul_latency: got %0d cycles, want 2", lat);
    end
    vectors++;
    if ({rh, rl, rd} !== {32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0}) begin
      miscompares++;
      $display("FAIL fast_mul_signed: got hi=%h lo=%h dbz=%b, want hi=ffffffff lo=fffffff1 dbz=0",
               rh, rl, rd);
    end
    @(posedge clk);
    #1;
    do_op(1, 1'b1, 1'b0, 32'd100, 32'd7, lat, rh, rl, rd);
    vectors++;
    if (lat !== 35 || {rh, rl, rd} !== {32'd2, 32'd14, 1'b0}) begin
      miscompares++;
      $display("FAIL fast_div: got lat=%0d hi=%h lo=%h dbz=%b, want lat=35 hi=2 lo=e dbz=0",
               lat, rh, rl, rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cancel();
    int lat, pulses;
    logic [31:0] rh, rl;
    logic rd;
    do_op(0, 1'b1, 1'b0, 32'd1000, 32'd10, lat, rh, rl, rd);
    @(posedge clk);
    #1;
    a0 = 32'd55; b0 = 32'd5; op_v[0] = 1'b1; sgn_v[0] = 1'b0;
    start_v[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cancel_v[0] = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (busy_v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_busy: got %b, want 0", busy_v[0]);
    end
    cancel_v[0] = 1'b0;
    start_v[0] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_v[0]) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL cancel_no_ready: got %0d pulses, want 0", pulses);
    end
    vectors++;
    if ({hi0, lo0} !== {32'd0, 32'd100}) begin
      miscompares++;
      $display("FAIL cancel_hold: got hi=%h lo=%h, want hi=0 lo=64", hi0, lo0);
    end
    start_v[0] = 1'b1;
    cancel_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    cancel_v[0] = 1'b0;
    vectors++;
    if (busy_v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_with_start: got busy=%b, want 0", busy_v[0]);
    end
    do_op(0, 1'b1, 1'b0, 32'd55, 32'd5, lat, rh, rl, rd);
    vectors++;
    if (lat !== 35 || {rh, rl, rd} !== {32'd0, 32'd11, 1'b0}) begin
      miscompares++;
      $display("FAIL cancel_restart: got lat=%0d hi=%h lo=%h dbz=%b, want lat=35 hi=0 lo=b dbz=0",
               lat, rh, rl, rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold_start();
    int lat, pulses, busy_seen;
    a2 = 8'd200; b2 = 8'd13; op_v[2] = 1'b1; sgn_v[2] = 1'b0;
    start_v[2] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready_v[2] && lat < 100);
    vectors++;
    if (lat !== 11 || {hi2, lo2} !== {8'd5, 8'd15}) begin
      miscompares++;
      $display("FAIL w8_div: got lat=%0d hi=%0d lo=%0d, want lat=11 hi=5 lo=15", lat, hi2, lo2);
    end
    @(posedge clk);
    #1;
    start_v[2] = 1'b0;
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (ready_v[2]) pulses++;
      if (busy_v[2]) busy_seen++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (pulses !== 0 || busy_seen !== 0) begin
      miscompares++;
      $display("FAIL hold_start_relaunch: got %0d ready, %0d busy cycles, want 0 and 0",
               pulses, busy_seen);
    end
  endtask

  task automatic test_random();
    int lat, d, w, sel, want_lat;
    logic o, s;
    logic [31:0] aa, bb, rh, rl, mh, ml;
    logic rd, md;
    for (int i = 0; i < 60; i++) begin
      d = (i < 30) ? 0 : ((i < 40) ? 1 : 2);
      w = width_of(d);
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      aa = $urandom;
      bb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) bb = 32'd0;
      if (sel == 1) bb = 32'hFFFFFFFF;
      if (sel == 2) aa = 32'h1 << (w - 1);
      if (sel == 3) bb = bb & 32'hF;
      if (sel == 4) begin aa = 32'h1 << (w - 1); bb = 32'hFFFFFFFF; end
      model(w, o, s, aa, bb, mh, ml, md);
      want_lat = (d == 1 && !o) ? 2 : w + 3;
      do_op(d, o, s, aa, bb, lat, rh, rl, rd);
      vectors++;
      if (lat !== want_lat || {rh, rl, rd} !== {mh, ml, md}) begin
        miscompares++;
        $display("FAIL rand[%0d] dut%0d op=%b s=%b a=%h b=%h: got lat=%0d hi=%h lo=%h dbz=%b, want lat=%0d hi=%h lo=%h dbz=%b",
                 i, d, o, s, aa, bb, lat, rh, rl, rd, want_lat, mh, ml, md);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_midop();
    a0 = 32'd999; b0 = 32'd4; op_v[0] = 1'b1; sgn_v[0] = 1'b0;
    start_v[0] = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_v[0], ready_v[0], dbz_v[0], hi0, lo0} !== '0) begin
      miscompares++;
      $display("FAIL reset_midop: got busy=%b ready=%b dbz=%b hi=%h lo=%h, want all zero",
               busy_v[0], ready_v[0], dbz_v[0], hi0, lo0);
    end
    start_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fast_mul();
    test_cancel();
    test_hold_start();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
